// File: rtl/paillier_result_gather.sv
// Gathers N-word results from BLOCK_COUNT core channels into per-channel FIFOs and
// streams whole results out round-robin on a single valid/ready port.

module paillier_result_fifo #(
  parameter int K    = 128,
  parameter int D    = 64,
  parameter int CNTW = 7
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            wr_req,
  input  logic [K-1:0]    wr_data,
  input  logic            rd,
  output logic [K-1:0]    head,
  output logic [CNTW-1:0] cnt,
  output logic            ovf
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CNTW-1:0] DL = CNTW'(D);

  logic [K-1:0]  mem [D];
  logic [AW-1:0] wp, rp;
  logic          wr_ok;

  // A simultaneous read frees a slot, so a full FIFO still takes the write.
  assign wr_ok = wr_req && ((cnt < DL) || rd);
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr_ok) wp <= (wp == AW'(D-1)) ? '0 : wp + 1'b1;
      if (rd)    rp <= (rp == AW'(D-1)) ? '0 : rp + 1'b1;
      case ({wr_ok, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_req && !wr_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && wr_ok) mem[wp] <= wr_data;
  end
endmodule

module paillier_result_gather #(
  parameter int BLOCK_COUNT   = 29,
  parameter int K             = 128,
  parameter int N             = 32,
  parameter int DEPTH_RESULTS = 2,
  localparam int D    = DEPTH_RESULTS * N,
  localparam int CNTW = $clog2(D + 1),
  localparam int CHW  = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BLOCK_COUNT*K-1:0] in_data,
  input  logic [BLOCK_COUNT-1:0]   in_valid,
  input  logic [BLOCK_COUNT-1:0]   ch_enable,
  input  logic                     flush,
  output logic [K-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHW-1:0]           out_ch,
  output logic [IDXW-1:0]          out_idx,
  output logic                     out_last,
  output logic [BLOCK_COUNT-1:0]   ovf,
  output logic                     busy
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t state_q, state_d;
  logic   clr;
  logic [BLOCK_COUNT-1:0][K-1:0]    head;
  logic [BLOCK_COUNT-1:0][CNTW-1:0] cnt;
  logic [BLOCK_COUNT-1:0]           elig, rd, nonempty;
  logic [CHW-1:0] sel, rr_ptr, pick_ch;
  logic           pick_found, hs;
  int             idx;

  assign clr = rst || flush;
  assign hs  = (state_q == BURST) && out_ready;

  for (genvar c = 0; c < BLOCK_COUNT; c++) begin : g_lane
    assign elig[c]     = cnt[c] >= CNTW'(N);
    assign nonempty[c] = cnt[c] != '0;
    assign rd[c]       = hs && (sel == CHW'(c));

    paillier_result_fifo #(.K(K), .D(D), .CNTW(CNTW)) u_fifo (
      .clk     (clk),
      .clr     (clr),
      .wr_req  (in_valid[c] && ch_enable[c]),
      .wr_data (in_data[c*K +: K]),
      .rd      (rd[c]),
      .head    (head[c]),
      .cnt     (cnt[c]),
      .ovf     (ovf[c])
    );
  end

  // Round-robin scan starting at rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= BLOCK_COUNT) idx = idx - BLOCK_COUNT;
      if (!pick_found && elig[idx]) begin
        pick_found = 1'b1;
        pick_ch    = CHW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = BURST;
      BURST:   if (hs && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sel     <= '0;
      rr_ptr  <= '0;
      out_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_found) begin
        sel    <= pick_ch;
        rr_ptr <= (pick_ch == CHW'(BLOCK_COUNT-1)) ? '0 : pick_ch + 1'b1;
      end
      if (hs) out_idx <= out_last ? '0 : out_idx + 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == BURST)
      for (int c = 0; c < BLOCK_COUNT; c++)
        if (sel == CHW'(c)) out_data = head[c];
  end

  assign out_valid = state_q == BURST;
  assign out_ch    = sel;
  assign out_last  = (state_q == BURST) && (out_idx == IDXW'(N-1));
  assign busy      = (state_q == BURST) || (|nonempty);
endmodule

// File: tb/tb_paillier_result_gather.sv
// Directed bench for paillier_result_gather with 4 channels, 8-bit words, 4-word results.

module tb_paillier_result_gather;
  localparam int BC = 4, K = 8, N = 4, DR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BC*K-1:0] in_data = '0;
  logic [BC-1:0] in_valid = '0;
  logic [BC-1:0] ch_enable = '1;
  logic          flush = 1'b0;
  logic [K-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    out_ch;
  logic [1:0]    out_idx;
  logic          out_last;
  logic [BC-1:0] ovf;
  logic          busy;
  int            n_chk = 0, n_err = 0;
  int            gap;

  paillier_result_gather #(.BLOCK_COUNT(BC), .K(K), .N(N), .DEPTH_RESULTS(DR)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .ch_enable(ch_enable),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_idx(out_idx), .out_last(out_last), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  // bases holds the first byte per channel; successive words increment it.
  task automatic wr(input logic [BC-1:0] mask, input logic [31:0] bases, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = mask;
      for (int c = 0; c < BC; c++) in_data[c*K +: K] = bases[c*K +: K] + 8'(i);
      step();
    end
    in_valid = '0;
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("vld_timeout", 32'(out_valid), 1);
  endtask

  task automatic run_burst(input int ch, input logic [7:0] base, input logic [15:0] rpat,
                           output int g);
    int i, k;
    wait_vld(g);
    i = 0;
    k = 0;
    while (i < N && k < 40) begin
      out_ready = rpat[k % 16];
      chk("vld",  32'(out_valid), 1);
      chk("data", 32'(out_data), 32'(base + 8'(i)));
      chk("ch",   32'(out_ch), 32'(ch));
      chk("idx",  32'(out_idx), 32'(i));
      chk("last", 32'(out_last), 32'(i == N-1));
      if (out_ready) i++;
      k++;
      step();
    end
    out_ready = 1'b1;
    chk("words", 32'(i), N);
    chk("idle_vld", 32'(out_valid), 0);
    chk("idle_idx", 32'(out_idx), 0);
  endtask

  initial begin
    do_reset();
    chk("rst_vld",  32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch",   32'(out_ch), 0);
    chk("rst_idx",  32'(out_idx), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ovf",  32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);

    // disabled channel ignores writes
    ch_enable = 4'b1110;
    wr(4'b0001, 32'h0000_0099, 1);
    chk("dis_cnt0", 32'(dut.cnt[0]), 0);
    ch_enable = '1;

    // 1: single result on ch2
    wr(4'b0100, 32'h0010_0000, 4);
    run_burst(2, 8'h10, 16'hffff, gap);
    chk("t1_busy", 32'(busy), 0);

    // 2: three channels at once, served 0,1,3 with one idle cycle between
    do_reset();
    wr(4'b1011, 32'h3000_2008, 4);
    run_burst(0, 8'h08, 16'hffff, gap);
    run_burst(1, 8'h20, 16'hffff, gap);
    chk("t2_gap1", 32'(gap), 1);
    run_burst(3, 8'h30, 16'hffff, gap);
    chk("t2_gap3", 32'(gap), 1);
    chk("t2_busy", 32'(busy), 0);

    // 3: overflow on ch1 while stalled
    do_reset();
    out_ready = 1'b0;
    wr(4'b0010, 32'h0000_2100, 9);
    chk("t3_cnt", 32'(dut.cnt[1]), 8);
    chk("t3_ovf", 32'(ovf), 32'h2);
    run_burst(1, 8'h21, 16'hffff, gap);
    run_burst(1, 8'h25, 16'hffff, gap);
    chk("t3_gap", 32'(gap), 1);
    chk("t3_ovf_sticky", 32'(ovf), 32'h2);
    chk("t3_busy", 32'(busy), 0);

    // 4: alternating ready
    wr(4'b0001, 32'h0000_0040, 4);
    run_burst(0, 8'h40, 16'h5555, gap);

    // 5: flush after two words; a write in the flush cycle is discarded
    wr(4'b0100, 32'h0050_0000, 4);
    wait_vld(gap);
    chk("t5_w0", 32'(out_data), 32'h50);
    step();
    chk("t5_w1", 32'(out_data), 32'h51);
    step();
    chk("t5_idx2", 32'(out_idx), 2);
    flush = 1'b1;
    in_valid = 4'b0010;
    in_data = 32'h0000_7700;
    step();
    flush = 1'b0;
    in_valid = '0;
    chk("t5_vld",  32'(out_valid), 0);
    chk("t5_idx",  32'(out_idx), 0);
    chk("t5_cnt2", 32'(dut.cnt[2]), 0);
    chk("t5_cnt1", 32'(dut.cnt[1]), 0);
    chk("t5_ovf",  32'(ovf), 0);
    chk("t5_rr",   32'(dut.rr_ptr), 0);
    chk("t5_busy", 32'(busy), 0);
    wr(4'b1000, 32'h6000_0000, 4);
    run_burst(3, 8'h60, 16'hffff, gap);

    // 6: reset mid-burst with ch3 holding a full result
    wr(4'b1100, 32'h8070_0000, 4);
    wait_vld(gap);
    step();
    rst = 1'b1;
    step();
    chk("t6_vld",  32'(out_valid), 0);
    chk("t6_data", 32'(out_data), 0);
    chk("t6_ch",   32'(out_ch), 0);
    chk("t6_idx",  32'(out_idx), 0);
    chk("t6_last", 32'(out_last), 0);
    chk("t6_ovf",  32'(ovf), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cnt3", 32'(dut.cnt[3]), 0);
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
